// File: rtl/prim_clock_gate_ctrl.sv
// prim_clock_gate_ctrl: idle-detect and sleep-handshake controller driving a clock gating cell enable
module prim_clock_gate_ctrl #(
  parameter int IdleCycles = 16,
  parameter int WakeCycles = 2,
  parameter int CntW       = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic busy_i,
  input  logic wake_i,
  input  logic force_on_i,
  input  logic sleep_ack_i,
  output logic sleep_req_o,
  output logic en_o,
  output logic gated_o,
  output logic ready_o
);
  if (IdleCycles < 1 || IdleCycles > 255) begin : g_bad_idle
    $error("IdleCycles out of range 1..255");
  end
  if (WakeCycles < 1 || WakeCycles > 255) begin : g_bad_wake
    $error("WakeCycles out of range 1..255");
  end
  if ((64'd1 << CntW) <= 64'(IdleCycles) || (64'd1 << CntW) <= 64'(WakeCycles)) begin : g_bad_cntw
    $error("CntW too narrow for IdleCycles/WakeCycles");
  end
  typedef enum logic [2:0] {ACTIVE, COUNT, REQ, GATED, WAKE} state_e;
  state_e state, state_d;
  logic [CntW-1:0] cnt, cnt_d;
  logic idle, wake_cond;
  assign idle      = !busy_i && !wake_i && !force_on_i;
  assign wake_cond = wake_i || force_on_i;
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      ACTIVE: begin
        state_d = idle ? (IdleCycles == 1 ? REQ : COUNT) : ACTIVE;
        cnt_d   = CntW'(idle && IdleCycles != 1);
      end
      COUNT: begin
        state_d = !idle ? ACTIVE : (cnt == CntW'(IdleCycles - 1)) ? REQ : COUNT;
        cnt_d   = (state_d == COUNT) ? cnt + 1'b1 : '0;
      end
      // abort beats the acknowledge so a late busy/wake never gates the clock
      REQ:     state_d = !idle ? ACTIVE : sleep_ack_i ? GATED : REQ;
      GATED: begin
        state_d = wake_cond ? WAKE : GATED;
        cnt_d   = '0;
      end
      WAKE: begin
        state_d = (cnt == CntW'(WakeCycles - 1)) ? ACTIVE : WAKE;
        cnt_d   = (state_d == WAKE) ? cnt + 1'b1 : '0;
      end
      default: begin
        state_d = ACTIVE;
        cnt_d   = '0;
      end
    endcase
  end
  // outputs are registered decodes of the next state so en_o is glitch-free
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state       <= ACTIVE;
      cnt         <= '0;
      en_o        <= 1'b1;
      sleep_req_o <= 1'b0;
      gated_o     <= 1'b0;
      ready_o     <= 1'b1;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      en_o        <= state_d != GATED;
      sleep_req_o <= state_d == REQ || state_d == GATED;
      gated_o     <= state_d == GATED;
      ready_o     <= state_d != GATED && state_d != WAKE;
    end
  end
endmodule

// File: tb/tb_prim_clock_gate_ctrl.sv
// tb_prim_clock_gate_ctrl: directed checks of sleep/wake sequencing for two parameter sets
module tb_prim_clock_gate_ctrl;
  logic clk_i = 1'b0;
  logic rst_ni, busy, wake, force_on, ack;
  logic req, en, gated, ready;
  logic b_busy, b_wake, b_force, b_ack;
  logic b_req, b_en, b_gated, b_ready;
  int total = 0, bad = 0;
  logic live = 1'b0;
  always #5 clk_i = ~clk_i;
  prim_clock_gate_ctrl #(.IdleCycles(4), .WakeCycles(2), .CntW(8)) u_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .busy_i(busy), .wake_i(wake), .force_on_i(force_on),
    .sleep_ack_i(ack), .sleep_req_o(req), .en_o(en), .gated_o(gated), .ready_o(ready)
  );
  prim_clock_gate_ctrl #(.IdleCycles(1), .WakeCycles(1), .CntW(8)) u_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .busy_i(b_busy), .wake_i(b_wake), .force_on_i(b_force),
    .sleep_ack_i(b_ack), .sleep_req_o(b_req), .en_o(b_en), .gated_o(b_gated), .ready_o(b_ready)
  );
  task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  // invariants: en low only when gated, en falls only out of REQ with ack, req with !ready only when gated
  logic p_en = 1'b1, p_req_st = 1'b0, p_ack = 1'b0;
  logic q_en = 1'b1, q_req_st = 1'b0, q_ack = 1'b0;
  always @(negedge clk_i) if (live) begin
    chk("inv_a_en_gated", {3'b0, en | gated}, 4'd1);
    chk("inv_a_req_ready", {3'b0, !req | ready | gated}, 4'd1);
    chk("inv_a_en_fall", {3'b0, !(p_en && !en) || (p_req_st && p_ack)}, 4'd1);
    chk("inv_b_en_gated", {3'b0, b_en | b_gated}, 4'd1);
    chk("inv_b_en_fall", {3'b0, !(q_en && !b_en) || (q_req_st && q_ack)}, 4'd1);
    p_en = en; p_req_st = req && en; p_ack = ack;
    q_en = b_en; q_req_st = b_req && b_en; q_ack = b_ack;
  end
  // outputs packed as {en, req, gated, ready}
  initial begin
    rst_ni = 1'b0; busy = 1'b1; wake = 1'b0; force_on = 1'b0; ack = 1'b0;
    b_busy = 1'b1; b_wake = 1'b0; b_force = 1'b0; b_ack = 1'b0;
    step(2);
    chk("reset_a", {en, req, gated, ready}, 4'b1001);
    chk("reset_b", {b_en, b_req, b_gated, b_ready}, 4'b1001);
    live = 1'b1;
    rst_ni = 1'b1; busy = 1'b0;
    step(3);
    chk("idle3_no_req", {en, req, gated, ready}, 4'b1001);
    step(1);
    chk("idle4_req", {en, req, gated, ready}, 4'b1101);
    step(1);
    chk("req_wait_ack", {en, req, gated, ready}, 4'b1101);
    ack = 1'b1;
    step(1);
    chk("gated", {en, req, gated, ready}, 4'b0110);
    busy = 1'b1;
    step(3);
    chk("gated_hold", {en, req, gated, ready}, 4'b0110);
    busy = 1'b0; wake = 1'b1;
    step(1);
    chk("wake_en", {en, req, gated, ready}, 4'b1000);
    wake = 1'b0; ack = 1'b0;
    step(1);
    chk("wake_settle", {en, req, gated, ready}, 4'b1000);
    step(1);
    chk("wake_ready", {en, req, gated, ready}, 4'b1001);
    busy = 1'b1;
    step(1);
    busy = 1'b0;
    step(3);
    busy = 1'b1;
    step(1);
    chk("hyst_abort", {en, req, gated, ready}, 4'b1001);
    busy = 1'b0;
    step(3);
    chk("hyst_recount3", {en, req, gated, ready}, 4'b1001);
    step(1);
    chk("hyst_recount4", {en, req, gated, ready}, 4'b1101);
    ack = 1'b1; wake = 1'b1;
    step(1);
    chk("req_abort", {en, req, gated, ready}, 4'b1001);
    ack = 1'b0; wake = 1'b0; force_on = 1'b1;
    step(6);
    chk("force_stay", {en, req, gated, ready}, 4'b1001);
    force_on = 1'b0;
    step(4);
    chk("force_off_req", {en, req, gated, ready}, 4'b1101);
    ack = 1'b1;
    step(1);
    chk("gated2", {en, req, gated, ready}, 4'b0110);
    force_on = 1'b1;
    step(1);
    chk("force_wake_en", {en, req, gated, ready}, 4'b1000);
    step(1);
    chk("force_wake_settle", {en, req, gated, ready}, 4'b1000);
    step(1);
    chk("force_wake_ready", {en, req, gated, ready}, 4'b1001);
    force_on = 1'b0; ack = 1'b0;
    step(4);
    chk("resleep_req", {en, req, gated, ready}, 4'b1101);
    ack = 1'b1;
    step(1);
    chk("gated3", {en, req, gated, ready}, 4'b0110);
    rst_ni = 1'b0;
    step(1);
    chk("reset_mid_sleep", {en, req, gated, ready}, 4'b1001);
    rst_ni = 1'b1; ack = 1'b0;
    step(3);
    chk("post_reset_count3", {en, req, gated, ready}, 4'b1001);
    step(1);
    chk("post_reset_req", {en, req, gated, ready}, 4'b1101);
    busy = 1'b1;
    step(1);
    chk("busy_abort", {en, req, gated, ready}, 4'b1001);
    b_busy = 1'b0;
    step(1);
    chk("b_idle1_req", {b_en, b_req, b_gated, b_ready}, 4'b1101);
    b_ack = 1'b1;
    step(1);
    chk("b_gated", {b_en, b_req, b_gated, b_ready}, 4'b0110);
    b_ack = 1'b0; b_wake = 1'b1;
    step(1);
    chk("b_wake_en", {b_en, b_req, b_gated, b_ready}, 4'b1000);
    b_wake = 1'b0; b_busy = 1'b1;
    step(1);
    chk("b_wake_ready", {b_en, b_req, b_gated, b_ready}, 4'b1001);
    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
